// File: rtl/bookkeeping_directory_arbiter_if.sv
// Client-side and directory-side handshake bundles for the bookkeeping directory arbiter.
// Client modports: master = L1 bookkeeping logic, slave = arbiter. Directory modports: master = arbiter, slave = directory.
interface bookkeeping_directory_arbiter_client_if #(
    parameter int INDEX_WIDTH    = 12,
    parameter int TAG_WIDTH      = 18,
    parameter int MSI_STATE_SIZE = 2
);
    localparam int ROW   = MSI_STATE_SIZE + TAG_WIDTH;
    localparam int ENTRY = 4 * ROW;

    logic [3:0]               req_valid;
    logic [3:0]               req_ready;
    logic [4*INDEX_WIDTH-1:0] req_idx;
    logic [3:0]               req_write;
    logic [4*ROW-1:0]         req_row;
    logic [3:0]               resp_valid;
    logic [3:0]               resp_ready;
    logic [ENTRY-1:0]         resp_entry;

    modport master (
        output req_valid, req_idx, req_write, req_row, resp_ready,
        input  req_ready, resp_valid, resp_entry
    );

    modport slave (
        input  req_valid, req_idx, req_write, req_row, resp_ready,
        output req_ready, resp_valid, resp_entry
    );
endinterface

interface bookkeeping_directory_arbiter_dir_if #(
    parameter int INDEX_WIDTH    = 12,
    parameter int TAG_WIDTH      = 18,
    parameter int MSI_STATE_SIZE = 2
);
    localparam int ROW   = MSI_STATE_SIZE + TAG_WIDTH;
    localparam int ENTRY = 4 * ROW;
    localparam int PUT   = INDEX_WIDTH + 1 + ROW + 2;

    logic             dir_put_valid;
    logic             dir_put_ready;
    logic [PUT-1:0]   dir_put_request;
    logic             dir_get_valid;
    logic             dir_get_ready;
    logic [ENTRY-1:0] dir_get_response;

    modport master (
        output dir_put_valid, dir_put_request, dir_get_valid,
        input  dir_put_ready, dir_get_ready, dir_get_response
    );

    modport slave (
        input  dir_put_valid, dir_put_request, dir_get_valid,
        output dir_put_ready, dir_get_ready, dir_get_response
    );
endinterface

// File: rtl/bookkeeping_directory_arbiter.sv
// Round-robin arbiter sharing one bookkeeping directory between four L1 clients,
// one transaction in flight at a time; read entries are routed back to the requester.
module bookkeeping_directory_arbiter #(
    parameter int INDEX_WIDTH    = 12,
    parameter int TAG_WIDTH      = 18,
    parameter int MSI_STATE_SIZE = 2
) (
    input  logic CLK,
    input  logic RST,
    bookkeeping_directory_arbiter_client_if.slave cli,
    bookkeeping_directory_arbiter_dir_if.master   dir,
    output logic busy
);
    localparam int ROW   = MSI_STATE_SIZE + TAG_WIDTH;
    localparam int ENTRY = 4 * ROW;

    typedef enum logic [1:0] {IDLE, ISSUE, GET, RESP} state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             rr_ptr_reg;
    logic [1:0]             g_reg;
    logic [INDEX_WIDTH-1:0] idx_reg;
    logic                   write_reg;
    logic [ROW-1:0]         row_reg;
    logic [ENTRY-1:0]       resp_entry_reg;

    logic [INDEX_WIDTH-1:0] idx_arr [4];
    logic [ROW-1:0]         row_arr [4];
    logic [3:0]             req_ready_vec;
    logic [3:0]             resp_valid_vec;
    logic                   found;
    logic [1:0]             grant;
    logic                   grant_en;

    // Rotating priority scan starting at rr_ptr.
    always_comb begin
        logic [1:0] cand;
        cand  = '0;
        found = 1'b0;
        grant = rr_ptr_reg;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_reg + 2'(k);
            if (!found && cli.req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Reset also masks req_ready, since req_valid may be high while reset is held.
    assign grant_en = !RST && (state_reg == IDLE) && found;

    for (genvar gi = 0; gi < 4; gi++) begin : g_client
        assign idx_arr[gi]        = cli.req_idx[gi*INDEX_WIDTH +: INDEX_WIDTH];
        assign row_arr[gi]        = cli.req_row[gi*ROW +: ROW];
        assign req_ready_vec[gi]  = grant_en && (grant == 2'(gi));
        assign resp_valid_vec[gi] = (state_reg == RESP) && (g_reg == 2'(gi));
    end

    assign cli.req_ready  = req_ready_vec;
    assign cli.resp_valid = resp_valid_vec;
    assign cli.resp_entry = resp_entry_reg;

    assign dir.dir_put_valid   = (state_reg == ISSUE);
    assign dir.dir_put_request = {idx_reg, write_reg, row_reg, g_reg[1], g_reg[0]};
    assign dir.dir_get_valid   = (state_reg == GET);
    assign busy                = (state_reg != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Writes finish at put acceptance; only reads wait for the directory get.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (found)                   state_next = ISSUE;
            ISSUE:   if (dir.dir_put_ready)       state_next = write_reg ? IDLE : GET;
            GET:     if (dir.dir_get_ready)       state_next = RESP;
            RESP:    if (cli.resp_ready[g_reg])   state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr_reg     <= '0;
            g_reg          <= '0;
            idx_reg        <= '0;
            write_reg      <= 1'b0;
            row_reg        <= '0;
            resp_entry_reg <= '0;
        end else begin
            if (state_reg == IDLE && found) begin
                g_reg      <= grant;
                idx_reg    <= idx_arr[grant];
                write_reg  <= cli.req_write[grant];
                row_reg    <= row_arr[grant];
                rr_ptr_reg <= grant + 2'd1;
            end
            if (state_reg == GET && dir.dir_get_ready) begin
                resp_entry_reg <= dir.dir_get_response;
            end
        end
    end
endmodule
